// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath definitions.
// Holds the fetch-stage constants and the payload carried from fetch to decode.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } inst_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO between instruction memory and decode.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   clr             - empties the FIFO (pointers and count to zero)
//   push, push_entry - write push_entry at the tail
//   pop             - advance the head
//   count           - number of valid entries (0..DEPTH)
//   head            - entry at the head pointer (meaningful when count != 0)
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           push,
  input  inst_entry_t                    push_entry,
  input  logic                           pop,
  output logic [$clog2(DEPTH):0]         count,
  output inst_entry_t                    head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  inst_entry_t     mem [DEPTH];
  logic [PW-1:0]   head_ptr;
  logic [PW-1:0]   tail_ptr;
  logic [CW-1:0]   count_q;

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PW'(1);
      if (pop)  head_ptr <= head_ptr + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: only slots covered by count are ever presented.
  always_ff @(posedge clk) begin
    if (!rst && !clr && push) mem[tail_ptr] <= push_entry;
  end

  assign count = count_q;
  assign head  = mem[head_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from combinational imem,
// buffers {pc, instr} in a prefetch FIFO and hands them to decode.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   imem_addr/rd     - instruction memory address (fetch_pc) and returned word
//   redirect_valid/pc - taken branch/jump from execute (highest priority)
//   id_valid/ready   - handshake with decode
//   id_instr/pc/pc_plus4 - head entry; NOP/0/0 when id_valid is low
//   misalign         - last redirect target had nonzero low bits
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        misalign
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic            misalign_q;
  logic [CW-1:0]   count;
  inst_entry_t     head;
  inst_entry_t     push_entry;
  logic            push;
  logic            pop;

  // Push uses the pre-pop count, so a full FIFO never pushes even while draining.
  assign push       = !redirect_valid && (count < CW'(DEPTH));
  assign pop        = id_valid && id_ready;
  assign push_entry = '{pc: fetch_pc, instr: imem_rd};

  // PC and misalign state; redirect beats sequential advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      misalign_q <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc   <= {redirect_pc[31:2], 2'b00};
      misalign_q <= |redirect_pc[1:0];
    end else if (push) begin
      fetch_pc   <= fetch_pc + PC_STEP;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clr        (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (count),
    .head       (head)
  );

  // Decode-facing outputs come only from registered state.
  assign id_valid    = (count != '0);
  assign id_instr    = id_valid ? head.instr : NOP_INSTR;
  assign id_pc       = id_valid ? head.pc : '0;
  assign id_pc_plus4 = id_valid ? (head.pc + PC_STEP) : '0;
  assign imem_addr   = fetch_pc;
  assign misalign    = misalign_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the single-core RISC-V datapath. Owns the program counter, drives the word-aligned address into the combinational instruction memory, captures the returned instruction word together with its PC, and hands both to decode over a valid/ready handshake through a small prefetch FIFO. Sits directly upstream of the instruction memory and decode; accepts taken-branch/jump redirects from execute.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- DEPTH, 2, prefetch FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- imem_addr  out  32  byte address to instruction memory, always fetch_pc
- imem_rd  in  32  instruction word from memory, combinational from imem_addr in the same cycle
- redirect_valid  in  1  execute requests PC change this cycle
- redirect_pc  in  32  redirect target byte address
- id_valid  out  1  head FIFO entry valid for decode
- id_ready  in  1  decode accepts head entry
- id_instr  out  32  head instruction; 32'h0000_0013 (NOP) when id_valid=0
- id_pc  out  32  PC of head instruction; 0 when id_valid=0
- id_pc_plus4  out  32  id_pc + 4 (mod 2^32); 0 when id_valid=0
- misalign  out  1  last redirect target had nonzero bits [1:0]

## Operation
- State: fetch_pc (32b), FIFO of DEPTH entries {pc, instr}, count (log2(DEPTH)+1 bits), misalign flag.
- push = !redirect_valid && count < DEPTH. On push: write {fetch_pc, imem_rd} at tail; fetch_pc ← fetch_pc + 4, wraps 32'hFFFF_FFFC → 0.
- pop = id_valid && id_ready. On pop: advance head.
- Push never depends on id_ready (no id_ready → imem path). Full FIFO with pop: no push that cycle; push resumes next cycle.
- Push and pop in the same cycle: count unchanged.
- Redirect (highest priority): FIFO cleared (count ← 0, pointers ← 0), no push; fetch_pc ← {redirect_pc[31:2], 2'b00}; misalign ← |redirect_pc[1:0]. A handshake completing in the redirect cycle counts as transferred to decode; discarding it is decode's responsibility.
- misalign holds its value until the next redirect.
- Reset: fetch_pc ← RESET_PC, FIFO empty, misalign ← 0; outputs id_valid=0, id_instr=NOP, id_pc=0, id_pc_plus4=0, imem_addr=RESET_PC. Reset overrides redirect; reset mid-stream discards all entries.

## Timing
- imem_addr is a register output; imem_rd is sampled at the same edge that advances fetch_pc.
- First fetch: rst low at edge 0 → entry pushed at edge 1 → id_valid=1 with RESET_PC instruction in cycle after edge 1.
- Redirect sampled at edge n: imem_addr=target during cycle n..n+1, target entry pushed at edge n+1, visible on id_* after edge n+1 (2-cycle redirect penalty).
- Steady state with id_ready=1: one instruction per cycle, count stays at 1.
- id_ready low: FIFO fills to DEPTH in DEPTH cycles, then fetch_pc holds; no instruction lost or duplicated.
- id_* outputs driven from FIFO head register, no combinational path from any input.

## Structure
- Shared package riscv_pkg: XLEN=32, NOP_INSTR=32'h0000_0013, PC_STEP=4, inst_entry_t {pc, instr}.
- One sub-module: fetch_fifo (synchronous DEPTH-entry FIFO with clear, push, pop, count, head outputs). fetch_unit holds PC logic, push/pop control, misalign and output muxing.

## Test plan
- Reset then id_ready=1 for 4 cycles with imem returning word = address: id_pc 0,4,8,12 on consecutive cycles, id_instr matches, id_pc_plus4 = id_pc+4.
- id_ready=0 for 5 cycles after reset: count reaches 2, imem_addr holds at 8; release ready → entries 0,4 then 8 delivered in order, no gaps or duplicates.
- Redirect to 32'h0000_0100 while FIFO holds 2 entries: next cycle id_valid=0, following cycle id_pc=0x100, misalign=0.
- Redirect to 32'h0000_0102: fetch from 0x100, misalign=1; later redirect to 0x200 clears misalign.
- RESET_PC=32'hFFFF_FFF8, ready=1: id_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; id_pc_plus4 of FFFF_FFFC is 0.
- Assert rst mid-stream with redirect_valid=1: next cycle id_valid=0, imem_addr=RESET_PC, misalign=0.
